// File: rtl/sq_gen_pkg.sv
// sq_gen_pkg: shared state encoding and default sizes for the square-wave generator
package sq_gen_pkg;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_HIGH = 2'd1, S_LOW = 2'd2, S_DONE = 2'd3} state_t;
  localparam int CNT_W_DEF = 24;
  localparam int BURST_W_DEF = 8;
  localparam int DEFAULT_HIGH_DEF = 25000;
  localparam int DEFAULT_LOW_DEF = 25000;
endpackage

// File: rtl/sq_channel.sv
// sq_channel: one square-wave channel with shadowed config, burst counting and edge strobe
module sq_channel import sq_gen_pkg::*; #(
  parameter int CNT_W = CNT_W_DEF,
  parameter int BURST_W = BURST_W_DEF,
  parameter int DEFAULT_HIGH = DEFAULT_HIGH_DEF,
  parameter int DEFAULT_LOW = DEFAULT_LOW_DEF
) (
  input  logic               i_sysclk,
  input  logic               i_reset,
  input  logic               i_enable,
  input  logic               i_we,
  input  logic [CNT_W-1:0]   i_high,
  input  logic [CNT_W-1:0]   i_low,
  input  logic [BURST_W-1:0] i_burst,
  output logic               o_pulse,
  output logic               o_edge,
  output logic               o_done
);
  state_t r_state, w_state;
  logic [CNT_W-1:0] r_cnt, w_cnt, r_hi, w_hi, r_lo, w_lo, r_sh_high, r_sh_low, w_len;
  logic [BURST_W-1:0] r_bcnt, w_bcnt, r_burst, w_burst, r_sh_burst;
  logic r_en, r_pulse, r_edge, r_done, w_pulse, w_end, w_start;
  // Next-state logic: a period boundary reloads active config from the shadow copy
  always_comb begin
    w_state = r_state;
    w_cnt = r_cnt;
    w_bcnt = r_bcnt;
    w_hi = r_hi;
    w_lo = r_lo;
    w_burst = r_burst;
    w_end = 1'b0;
    w_start = 1'b0;
    w_len = r_sh_high != '0 ? r_sh_high : r_sh_low;
    if (!i_enable) begin
      w_state = S_IDLE;
      w_cnt = '0;
      w_bcnt = '0;
    end else begin
      case (r_state)
        S_IDLE: w_start = r_en;
        S_HIGH: begin
          if (r_cnt != '0) w_cnt = r_cnt - CNT_W'(1);
          else if (r_lo != '0) begin
            w_state = S_LOW;
            w_cnt = r_lo - CNT_W'(1);
          end else w_end = 1'b1;
        end
        S_LOW: if (r_cnt != '0) w_cnt = r_cnt - CNT_W'(1); else w_end = 1'b1;
        default: ;
      endcase
      if (w_end) begin
        w_bcnt = r_burst != '0 ? r_bcnt + BURST_W'(1) : r_bcnt;
        if (r_burst != '0 && w_bcnt == r_burst) begin
          w_state = S_DONE;
          w_cnt = '0;
        end else w_start = 1'b1;
      end
      if (w_start) begin
        w_hi = r_sh_high;
        w_lo = r_sh_low;
        w_burst = r_sh_burst;
        w_state = r_sh_high != '0 ? S_HIGH : S_LOW;
        w_cnt = w_len != '0 ? w_len - CNT_W'(1) : '0;
      end
    end
  end
  assign w_pulse = w_state == S_HIGH;
  // State, counters, active config and registered outputs
  always_ff @(posedge i_sysclk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_cnt <= '0;
      r_bcnt <= '0;
      r_hi <= CNT_W'(DEFAULT_HIGH);
      r_lo <= CNT_W'(DEFAULT_LOW);
      r_burst <= '0;
      r_en <= 1'b0;
      r_pulse <= 1'b0;
      r_edge <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt <= w_cnt;
      r_bcnt <= w_bcnt;
      r_hi <= w_hi;
      r_lo <= w_lo;
      r_burst <= w_burst;
      r_en <= i_enable;
      r_pulse <= w_pulse;
      r_edge <= w_pulse & ~r_pulse;
      r_done <= w_state == S_DONE;
    end
  end
  // Shadow config captured on write; only read at period boundaries
  always_ff @(posedge i_sysclk or posedge i_reset) begin
    if (i_reset) begin
      r_sh_high <= CNT_W'(DEFAULT_HIGH);
      r_sh_low <= CNT_W'(DEFAULT_LOW);
      r_sh_burst <= '0;
    end else if (i_we) begin
      r_sh_high <= i_high;
      r_sh_low <= i_low;
      r_sh_burst <= i_burst;
    end
  end
  assign o_pulse = r_pulse;
  assign o_edge = r_edge;
  assign o_done = r_done;
endmodule

// File: rtl/multi_square_gen.sv
// multi_square_gen: independent square-wave channels behind a shared config write port
module multi_square_gen import sq_gen_pkg::*; #(
  parameter int CHANNELS = 4,
  parameter int CNT_W = CNT_W_DEF,
  parameter int BURST_W = BURST_W_DEF,
  parameter int DEFAULT_HIGH = DEFAULT_HIGH_DEF,
  parameter int DEFAULT_LOW = DEFAULT_LOW_DEF,
  localparam int CH_W = CHANNELS > 1 ? $clog2(CHANNELS) : 1
) (
  input  logic                sysclk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] enable,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [CNT_W-1:0]    cfg_high,
  input  logic [CNT_W-1:0]    cfg_low,
  input  logic [BURST_W-1:0]  cfg_burst,
  output logic [CHANNELS-1:0] pulse,
  output logic [CHANNELS-1:0] edge_strb,
  output logic [CHANNELS-1:0] done
);
  logic [CHANNELS-1:0] w_we;
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    assign w_we[i] = cfg_we && cfg_ch == CH_W'(i);
    sq_channel #(
      .CNT_W(CNT_W),
      .BURST_W(BURST_W),
      .DEFAULT_HIGH(DEFAULT_HIGH),
      .DEFAULT_LOW(DEFAULT_LOW)
    ) u_ch (
      .i_sysclk(sysclk),
      .i_reset(reset),
      .i_enable(enable[i]),
      .i_we(w_we[i]),
      .i_high(cfg_high),
      .i_low(cfg_low),
      .i_burst(cfg_burst),
      .o_pulse(pulse[i]),
      .o_edge(edge_strb[i]),
      .o_done(done[i])
    );
  end
endmodule

// File: tb/tb_multi_square_gen.sv
// tb_multi_square_gen: directed checks of timing, reconfig, burst, degenerate and reset behaviour
module tb_multi_square_gen;
  logic sysclk = 1'b0, reset = 1'b1;
  logic [3:0] enable = '0, pulse, edge_strb, done;
  logic cfg_we = 1'b0, cfg_we2 = 1'b0;
  logic [1:0] cfg_ch = '0, cfg_ch2 = '0;
  logic [23:0] cfg_high = '0, cfg_low = '0;
  logic [7:0] cfg_burst = '0;
  logic [2:0] enable2 = '0, pulse2, edge2, done2;
  int tests = 0, fails = 0;

  multi_square_gen dut (
    .sysclk(sysclk), .reset(reset), .enable(enable), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_high(cfg_high), .cfg_low(cfg_low), .cfg_burst(cfg_burst),
    .pulse(pulse), .edge_strb(edge_strb), .done(done)
  );

  multi_square_gen #(.CHANNELS(3), .DEFAULT_HIGH(6), .DEFAULT_LOW(6)) dut2 (
    .sysclk(sysclk), .reset(reset), .enable(enable2), .cfg_we(cfg_we2), .cfg_ch(cfg_ch2),
    .cfg_high(cfg_high), .cfg_low(cfg_low), .cfg_burst(cfg_burst),
    .pulse(pulse2), .edge_strb(edge2), .done(done2)
  );

  always #10 sysclk = ~sysclk;

  task automatic tick(input int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  task automatic wr(input logic [1:0] ch, input int hi, input int lo, input int b);
    cfg_ch = ch;
    cfg_high = 24'(hi);
    cfg_low = 24'(lo);
    cfg_burst = 8'(b);
    cfg_we = 1'b1;
    tick(1);
    cfg_we = 1'b0;
  endtask

  task automatic run_len(input int ch, input logic lvl, output int n);
    n = 0;
    while (pulse[ch] === lvl && n < 60000) begin
      tick(1);
      n++;
    end
  endtask

  task automatic observe(input int ch, input int cycles, output int hi, output int ed, output int fd);
    hi = 0;
    ed = 0;
    fd = -1;
    for (int t = 0; t < cycles; t++) begin
      tick(1);
      if (pulse[ch] === 1'b1) hi++;
      if (edge_strb[ch] === 1'b1) ed++;
      if (done[ch] === 1'b1 && fd < 0) fd = t;
    end
  endtask

  task automatic test_reset;
    #50;
    tests++;
    if ({pulse, edge_strb, done, pulse2, edge2, done2} !== '0) begin
      fails++;
      $display("FAIL reset_outputs got p=%b e=%b d=%b p2=%b want all 0", pulse, edge_strb, done, pulse2);
    end
    #50 reset = 1'b0;
    tick(1);
  endtask

  task automatic test_defaults;
    int n;
    enable[0] = 1'b1;
    tick(1);
    tests++;
    if (pulse[0] !== 1'b0) begin fails++; $display("FAIL def_latency pulse=%b want 0", pulse[0]); end
    tick(1);
    tests++;
    if (pulse[0] !== 1'b1 || edge_strb[0] !== 1'b1) begin
      fails++;
      $display("FAIL def_first_edge pulse=%b edge=%b want 1 1", pulse[0], edge_strb[0]);
    end
    tick(1);
    tests++;
    if (edge_strb[0] !== 1'b0) begin fails++; $display("FAIL def_edge_width edge=%b want 0", edge_strb[0]); end
    run_len(0, 1'b1, n);
    tests++;
    if (n != 24999) begin fails++; $display("FAIL def_high_len got %0d want 24999", n); end
    run_len(0, 1'b0, n);
    tests++;
    if (n != 25000) begin fails++; $display("FAIL def_low_len got %0d want 25000", n); end
    tests++;
    if (edge_strb[0] !== 1'b1 || pulse[3:1] !== 3'b000) begin
      fails++;
      $display("FAIL def_second_edge edge=%b others=%b want 1 000", edge_strb[0], pulse[3:1]);
    end
    enable[0] = 1'b0;
    tick(1);
    tests++;
    if (pulse[0] !== 1'b0) begin fails++; $display("FAIL def_disable pulse=%b want 0", pulse[0]); end
  endtask

  task automatic test_reconfig;
    int n;
    wr(2'd1, 10, 30, 0);
    enable[1] = 1'b1;
    tick(2);
    tests++;
    if (pulse[1] !== 1'b1 || edge_strb[1] !== 1'b1) begin
      fails++;
      $display("FAIL rc_start pulse=%b edge=%b want 1 1", pulse[1], edge_strb[1]);
    end
    wr(2'd1, 4, 4, 0);
    run_len(1, 1'b1, n);
    tests++;
    if (n != 9) begin fails++; $display("FAIL rc_cur_high got %0d want 9", n); end
    run_len(1, 1'b0, n);
    tests++;
    if (n != 30) begin fails++; $display("FAIL rc_cur_low got %0d want 30", n); end
    tests++;
    if (edge_strb[1] !== 1'b1) begin fails++; $display("FAIL rc_new_edge edge=%b want 1", edge_strb[1]); end
    run_len(1, 1'b1, n);
    tests++;
    if (n != 4) begin fails++; $display("FAIL rc_new_high got %0d want 4", n); end
    run_len(1, 1'b0, n);
    tests++;
    if (n != 4) begin fails++; $display("FAIL rc_new_low got %0d want 4", n); end
    enable[1] = 1'b0;
    tick(1);
  endtask

  task automatic test_burst;
    int hi, ed, fd;
    wr(2'd2, 5, 5, 3);
    for (int r = 0; r < 2; r++) begin
      enable[2] = 1'b1;
      observe(2, 41, hi, ed, fd);
      tests++;
      if (ed != 3 || hi != 15) begin fails++; $display("FAIL burst_pulses run%0d edges=%0d high=%0d want 3 15", r, ed, hi); end
      tests++;
      if (fd != 31 || done[2] !== 1'b1 || pulse[2] !== 1'b0) begin
        fails++;
        $display("FAIL burst_done run%0d first=%0d done=%b pulse=%b want 31 1 0", r, fd, done[2], pulse[2]);
      end
      enable[2] = 1'b0;
      tick(1);
      tests++;
      if (done[2] !== 1'b0) begin fails++; $display("FAIL burst_clear run%0d done=%b want 0", r, done[2]); end
    end
  endtask

  task automatic test_toggle;
    int n;
    wr(2'd3, 1500, 500, 0);
    enable[3] = 1'b1;
    tick(1000);
    tests++;
    if (pulse[3] !== 1'b1) begin fails++; $display("FAIL tog_running pulse=%b want 1", pulse[3]); end
    enable[3] = 1'b0;
    tick(1);
    tests++;
    if (pulse[3] !== 1'b0) begin fails++; $display("FAIL tog_drop pulse=%b want 0", pulse[3]); end
    tick(3999);
    enable[3] = 1'b1;
    tick(1);
    tests++;
    if (pulse[3] !== 1'b0) begin fails++; $display("FAIL tog_latency pulse=%b want 0", pulse[3]); end
    tick(1);
    tests++;
    if (pulse[3] !== 1'b1 || edge_strb[3] !== 1'b1) begin
      fails++;
      $display("FAIL tog_restart pulse=%b edge=%b want 1 1", pulse[3], edge_strb[3]);
    end
    run_len(3, 1'b1, n);
    tests++;
    if (n != 1500) begin fails++; $display("FAIL tog_fresh_high got %0d want 1500", n); end
    enable[3] = 1'b0;
    tick(1);
  endtask

  task automatic test_degenerate;
    int hi, ed, fd;
    wr(2'd0, 0, 7, 2);
    enable[0] = 1'b1;
    observe(0, 21, hi, ed, fd);
    tests++;
    if (hi != 0 || ed != 0 || fd != 15) begin
      fails++;
      $display("FAIL deg_high0 high=%0d edges=%0d done_at=%0d want 0 0 15", hi, ed, fd);
    end
    enable[0] = 1'b0;
    tick(1);
    wr(2'd0, 3, 0, 0);
    enable[0] = 1'b1;
    observe(0, 31, hi, ed, fd);
    tests++;
    if (hi != 30 || ed != 1 || fd != -1) begin
      fails++;
      $display("FAIL deg_low0 high=%0d edges=%0d done_at=%0d want 30 1 -1", hi, ed, fd);
    end
    enable[0] = 1'b0;
    tick(1);
    wr(2'd0, 0, 0, 3);
    enable[0] = 1'b1;
    observe(0, 11, hi, ed, fd);
    tests++;
    if (hi != 0 || fd != 4) begin fails++; $display("FAIL deg_both0 high=%0d done_at=%0d want 0 4", hi, fd); end
    enable[0] = 1'b0;
    tick(1);
  endtask

  task automatic test_out_of_range;
    int cnt [3];
    cfg_ch2 = 2'd3;
    cfg_high = 24'd2;
    cfg_low = 24'd9;
    cfg_burst = 8'd0;
    cfg_we2 = 1'b1;
    tick(1);
    cfg_we2 = 1'b0;
    enable2 = 3'b111;
    for (int c = 0; c < 3; c++) cnt[c] = 0;
    for (int t = 0; t < 13; t++) begin
      tick(1);
      for (int c = 0; c < 3; c++) if (pulse2[c] === 1'b1) cnt[c]++;
    end
    for (int c = 0; c < 3; c++) begin
      tests++;
      if (cnt[c] != 6) begin fails++; $display("FAIL oor_ch%0d high=%0d want 6", c, cnt[c]); end
    end
    enable2 = 3'b000;
    tick(1);
  endtask

  task automatic test_async_reset;
    wr(2'd0, 50, 50, 0);
    enable = 4'hF;
    tick(2);
    tests++;
    if (pulse !== 4'hF || edge_strb !== 4'hF) begin
      fails++;
      $display("FAIL ar_pre pulse=%b edge=%b want 1111 1111", pulse, edge_strb);
    end
    #5 reset = 1'b1;
    #1;
    tests++;
    if ({pulse, edge_strb, done} !== '0) begin
      fails++;
      $display("FAIL ar_clear pulse=%b edge=%b done=%b want all 0", pulse, edge_strb, done);
    end
    enable = '0;
  endtask

  initial begin
    test_reset;
    test_defaults;
    test_reconfig;
    test_burst;
    test_toggle;
    test_degenerate;
    test_out_of_range;
    test_async_reset;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
